// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot player-shot manager.
// Launches a bullet from the lowest free slot on a fire request, moves every
// active bullet up by STEP each frame and retires it on a hit or at the ceiling.
// Optional feature macro: AUTOFIRE_EN (holding the fire key re-fires each time
// the cooldown expires instead of firing only on the press edge).

module bullet_slot #(
   parameter int COORD_W = 10,
   parameter int Y_START = 420,
   parameter int Y_MIN   = 0,
   parameter int STEP    = 4
) (
   input  logic               frame_clk,
   input  logic               Reset_n,
   input  logic               load,
   input  logic               hit,
   input  logic [COORD_W-1:0] load_x,
   output logic               active,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y
);
   localparam logic [COORD_W-1:0] Y_ST   = COORD_W'(Y_START);
   localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
   // one bit wider so Y_MIN+STEP cannot overflow the coordinate range
   localparam logic [COORD_W:0]   CEIL   = (COORD_W+1)'(Y_MIN + STEP);

   // slot state: a load beats everything, then hit, then ceiling, then climb
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         active <= 1'b0;
         x      <= '0;
         y      <= Y_ST;
      end else if (load) begin
         active <= 1'b1;
         x      <= load_x;
         y      <= Y_ST;
      end else if (active) begin
         if (hit || ({1'b0, y} < CEIL)) begin
            active <= 1'b0;
            y      <= Y_ST;
         end else begin
            y      <= y - STEP_C;
         end
      end
   end
endmodule

module bullet_pool #(
   parameter int         N_BULLETS = 4,
   parameter int         COORD_W   = 10,
   parameter int         Y_START   = 420,
   parameter int         Y_MIN     = 0,
   parameter int         STEP      = 4,
   parameter int         COOLDOWN  = 8,
   parameter logic [7:0] FIRE_KEY  = 8'h2C
) (
   input  logic                           frame_clk,
   input  logic                           Reset_n,
   input  logic [7:0]                     keycode,
   input  logic [COORD_W-1:0]             player_X,
   input  logic [N_BULLETS-1:0]           hit,
   output logic [N_BULLETS*COORD_W-1:0]   bullet_X,
   output logic [N_BULLETS*COORD_W-1:0]   bullet_Y,
   output logic [N_BULLETS-1:0]           bullet_active,
   output logic                           fire_pulse,
   output logic                           pool_full
);
   localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

   logic [7:0]                          key_hist;
   logic [CD_W-1:0]                     cooldown;
   logic [N_BULLETS-1:0]                free_sel;
   logic [N_BULLETS-1:0]                load;
   logic                                any_free;
   logic                                fire_req;
   logic                                launch;
   logic [N_BULLETS-1:0][COORD_W-1:0]   x_arr;
   logic [N_BULLETS-1:0][COORD_W-1:0]   y_arr;

`ifdef AUTOFIRE_EN
   assign fire_req = (keycode == FIRE_KEY);
`else
   assign fire_req = (keycode == FIRE_KEY) && (key_hist != FIRE_KEY);
`endif

   // lowest-index free slot, taken from the pre-update mask so a slot that
   // retires this frame only becomes allocatable next frame
   always_comb begin
      free_sel = '0;
      any_free = 1'b0;
      for (int i = 0; i < N_BULLETS; i++) begin
         if (!bullet_active[i] && !any_free) begin
            free_sel[i] = 1'b1;
            any_free    = 1'b1;
         end
      end
   end

   assign launch    = fire_req && (cooldown == '0) && any_free;
   assign load      = launch ? free_sel : '0;
   assign pool_full = &bullet_active;
   assign bullet_X  = x_arr;
   assign bullet_Y  = y_arr;

   // key history, launch cooldown and the one-frame fire pulse
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         key_hist   <= '0;
         cooldown   <= '0;
         fire_pulse <= 1'b0;
      end else begin
         key_hist   <= keycode;
         fire_pulse <= launch;
         if (launch)
            cooldown <= CD_W'(COOLDOWN);
         else if (cooldown != '0)
            cooldown <= cooldown - CD_W'(1);
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_BULLETS; g++) begin : g_slot
         bullet_slot #(
            .COORD_W (COORD_W),
            .Y_START (Y_START),
            .Y_MIN   (Y_MIN),
            .STEP    (STEP)
         ) u_slot (
            .frame_clk (frame_clk),
            .Reset_n   (Reset_n),
            .load      (load[g]),
            .hit       (hit[g]),
            .load_x    (player_X),
            .active    (bullet_active[g]),
            .x         (x_arr[g]),
            .y         (y_arr[g])
         );
      end
   endgenerate
endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: a behavioural model predicts each frame,
// the prediction is queued before the edge and checked after it.
module tb_bullet_pool;
   localparam int N = 4;
   localparam int W = 10;
   localparam int YS = 420;
   localparam int STP = 4;
   localparam int CD = 8;
   localparam logic [7:0] FK = 8'h2C;

   typedef struct {
      logic [N-1:0]   act;
      logic [N*W-1:0] x;
      logic [N*W-1:0] y;
      logic           fp;
      logic           full;
   } exp_t;

   logic           frame_clk = 1'b0;
   logic           Reset_n;
   logic [7:0]     keycode;
   logic [W-1:0]   player_X;
   logic [N-1:0]   hit;
   logic [N*W-1:0] bullet_X, bullet_Y;
   logic [N-1:0]   bullet_active;
   logic           fire_pulse, pool_full;

   bullet_pool dut (
      .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
      .player_X(player_X), .hit(hit), .bullet_X(bullet_X), .bullet_Y(bullet_Y),
      .bullet_active(bullet_active), .fire_pulse(fire_pulse), .pool_full(pool_full)
   );

   always #5 frame_clk = ~frame_clk;

   // model state
   bit           m_act [N];
   int           m_x   [N];
   int           m_y   [N];
   int           m_cd;
   logic [7:0]   m_hist;
   bit           m_fp;
   exp_t         sb[$];
   int           n_cmp = 0;
   int           n_err = 0;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = YS; end
      m_cd = 0; m_hist = 8'h00; m_fp = 0;
   endtask

   // predict the frame produced by the next edge and queue it
   task automatic model_step();
      bit fire, launch;
      int slot;
      exp_t e;
`ifdef AUTOFIRE_EN
      fire = (keycode == FK);
`else
      fire = (keycode == FK) && (m_hist != FK);
`endif
      slot = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
      launch = fire && (m_cd == 0) && (slot >= 0);
      for (int i = 0; i < N; i++) begin
         if (launch && i == slot) begin
            m_act[i] = 1; m_x[i] = int'(player_X); m_y[i] = YS;
         end else if (m_act[i]) begin
            if (hit[i] || m_y[i] < STP) begin m_act[i] = 0; m_y[i] = YS; end
            else m_y[i] = m_y[i] - STP;
         end
      end
      m_cd = launch ? CD : (m_cd > 0 ? m_cd - 1 : 0);
      m_fp = launch;
      m_hist = keycode;
      e.full = 1'b1;
      for (int i = 0; i < N; i++) begin
         e.act[i] = m_act[i];
         e.x[i*W +: W] = W'(m_x[i]);
         e.y[i*W +: W] = W'(m_y[i]);
         e.full = e.full & m_act[i];
      end
      e.fp = m_fp;
      sb.push_back(e);
   endtask

   task automatic advance();
      model_step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic test_reset();
      logic [N*W-1:0] ys;
      for (int i = 0; i < N; i++) ys[i*W +: W] = W'(YS);
      Reset_n = 1'b0; keycode = 8'h00; player_X = '0; hit = '0;
      model_reset();
      repeat (2) @(posedge frame_clk);
      #1;
      n_cmp++;
      if (bullet_active !== '0 || bullet_X !== '0 || bullet_Y !== ys ||
          fire_pulse !== 1'b0 || pool_full !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: act=%b x=%h y=%h fp=%b full=%b, expected act=0 x=0 y=%h fp=0 full=0",
                  bullet_active, bullet_X, bullet_Y, fire_pulse, pool_full, ys);
      end
      #3 Reset_n = 1'b1;
      @(posedge frame_clk);
      #1;
   endtask

   task automatic test_single_launch();
      exp_t e;
      keycode = FK; player_X = 10'd200;
      for (int f = 1; f <= 2; f++) begin
         advance();
         e = sb.pop_front();
         n_cmp++;
         if (bullet_active !== e.act || bullet_X !== e.x || bullet_Y !== e.y ||
             fire_pulse !== e.fp || pool_full !== e.full) begin
            n_err++;
            $display("FAIL single_launch f%0d: act=%b x=%h y=%h fp=%b full=%b, expected act=%b x=%h y=%h fp=%b full=%b",
                     f, bullet_active, bullet_X, bullet_Y, fire_pulse, pool_full, e.act, e.x, e.y, e.fp, e.full);
         end
         n_cmp++;
         if (f == 1 && (bullet_active !== 4'b0001 || bullet_X[W-1:0] !== 10'd200 ||
                        bullet_Y[W-1:0] !== 10'd420 || fire_pulse !== 1'b1)) begin
            n_err++;
            $display("FAIL launch_frame1: act=%b x0=%0d y0=%0d fp=%b, expected act=0001 x0=200 y0=420 fp=1",
                     bullet_active, bullet_X[W-1:0], bullet_Y[W-1:0], fire_pulse);
         end else if (f == 2 && (bullet_Y[W-1:0] !== 10'd416 || fire_pulse !== 1'b0)) begin
            n_err++;
            $display("FAIL launch_frame2: y0=%0d fp=%b, expected y0=416 fp=0", bullet_Y[W-1:0], fire_pulse);
         end
      end
   endtask

   task automatic test_hold_flight();
      exp_t e;
      keycode = FK;
      for (int i = 0; i < 105; i++) begin
         advance();
         e = sb.pop_front();
         n_cmp++;
         if (bullet_active !== e.act || bullet_X !== e.x || bullet_Y !== e.y ||
             fire_pulse !== e.fp || pool_full !== e.full) begin
            n_err++;
            $display("FAIL hold_flight i%0d: act=%b x=%h y=%h fp=%b full=%b, expected act=%b x=%h y=%h fp=%b full=%b",
                     i, bullet_active, bullet_X, bullet_Y, fire_pulse, pool_full, e.act, e.x, e.y, e.fp, e.full);
         end
         if (i == 103) begin
            n_cmp++;
            if (bullet_active[0] !== 1'b1 || bullet_Y[W-1:0] !== '0) begin
               n_err++;
               $display("FAIL last_move: act0=%b y0=%0d, expected act0=1 y0=0", bullet_active[0], bullet_Y[W-1:0]);
            end
         end
      end
      n_cmp++;
      if (bullet_active[0] !== 1'b0 || bullet_Y[W-1:0] !== 10'd420) begin
         n_err++;
         $display("FAIL ceiling_retire: act0=%b y0=%0d, expected act0=0 y0=420", bullet_active[0], bullet_Y[W-1:0]);
      end
`ifndef AUTOFIRE_EN
      n_cmp++;
      if (bullet_active !== '0) begin
         n_err++;
         $display("FAIL no_refire_on_hold: act=%b, expected 0000", bullet_active);
      end
`endif
   endtask

   task automatic test_cooldown_full();
      exp_t e;
      int launches = 0;
      for (int i = 0; i < 60; i++) begin
         keycode = (i % 2 == 0) ? FK : 8'h00;
         player_X = W'(20 + i);
         advance();
         e = sb.pop_front();
         launches += int'(fire_pulse);
         n_cmp++;
         if (bullet_active !== e.act || bullet_X !== e.x || bullet_Y !== e.y ||
             fire_pulse !== e.fp || pool_full !== e.full) begin
            n_err++;
            $display("FAIL cooldown i%0d: act=%b x=%h y=%h fp=%b full=%b, expected act=%b x=%h y=%h fp=%b full=%b",
                     i, bullet_active, bullet_X, bullet_Y, fire_pulse, pool_full, e.act, e.x, e.y, e.fp, e.full);
         end
      end
`ifndef AUTOFIRE_EN
      n_cmp++;
      if (launches != 4 || pool_full !== 1'b1) begin
         n_err++;
         $display("FAIL pool_block: launches=%0d full=%b, expected launches=4 full=1", launches, pool_full);
      end
`endif
   endtask

   task automatic test_hit_realloc();
      exp_t e;
      keycode = 8'h00; hit = 4'b0010;
      advance();
      e = sb.pop_front();
      n_cmp++;
      if (bullet_active !== e.act || bullet_Y !== e.y || bullet_active !== 4'b1101 ||
          bullet_Y[2*W-1:W] !== 10'd420) begin
         n_err++;
         $display("FAIL hit_retire: act=%b y1=%0d, expected act=%b (1101) y1=420",
                  bullet_active, bullet_Y[2*W-1:W], e.act);
      end
      // press while hit is still asserted on the now-free slot: launch wins
      keycode = FK; player_X = 10'd77; hit = 4'b0010;
      advance();
      e = sb.pop_front();
      n_cmp++;
      if (bullet_active !== e.act || bullet_X !== e.x || bullet_Y !== e.y ||
          fire_pulse !== e.fp || pool_full !== e.full) begin
         n_err++;
         $display("FAIL realloc: act=%b x=%h y=%h fp=%b full=%b, expected act=%b x=%h y=%h fp=%b full=%b",
                  bullet_active, bullet_X, bullet_Y, fire_pulse, pool_full, e.act, e.x, e.y, e.fp, e.full);
      end
      n_cmp++;
      if (bullet_active !== 4'b1111 || bullet_X[2*W-1:W] !== 10'd77 || fire_pulse !== 1'b1) begin
         n_err++;
         $display("FAIL realloc_slot1: act=%b x1=%0d fp=%b, expected act=1111 x1=77 fp=1",
                  bullet_active, bullet_X[2*W-1:W], fire_pulse);
      end
      hit = '0; keycode = 8'h00;
   endtask

   task automatic test_async_reset();
      exp_t e;
      logic [N*W-1:0] ys;
      for (int i = 0; i < N; i++) ys[i*W +: W] = W'(YS);
      advance();
      e = sb.pop_front();
      n_cmp++;
      if (bullet_active !== e.act || bullet_Y !== e.y) begin
         n_err++;
         $display("FAIL pre_reset: act=%b y=%h, expected act=%b y=%h", bullet_active, bullet_Y, e.act, e.y);
      end
      #2 Reset_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (bullet_active !== '0 || bullet_X !== '0 || bullet_Y !== ys ||
          fire_pulse !== 1'b0 || pool_full !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: act=%b x=%h y=%h fp=%b full=%b, expected act=0 x=0 y=%h fp=0 full=0",
                  bullet_active, bullet_X, bullet_Y, fire_pulse, pool_full, ys);
      end
      #2 Reset_n = 1'b1;
      keycode = FK; player_X = 10'd300;
      advance();
      e = sb.pop_front();
      n_cmp++;
      if (bullet_active !== e.act || bullet_X !== e.x || bullet_Y !== e.y ||
          fire_pulse !== e.fp || bullet_active !== 4'b0001 ||
          bullet_X[W-1:0] !== 10'd300 || fire_pulse !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_launch: act=%b x0=%0d fp=%b, expected act=0001 x0=300 fp=1",
                  bullet_active, bullet_X[W-1:0], fire_pulse);
      end
   endtask

   initial begin
      test_reset();
      test_single_launch();
      test_hold_flight();
      test_cooldown_full();
      test_hit_realloc();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
